// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter: merges NUM_PORTS AXI-stream requesters into one registered
// output stream, holding each grant for a whole packet. Define AXIS_ARB_STATS_EN for pkt_count.
module axis_packet_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 512
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NUM_PORTS-1:0]         s_axis_tvalid,
    output logic [NUM_PORTS-1:0]         s_axis_tready,
    input  logic [NUM_PORTS*WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]         s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [WIDTH-1:0]             m_axis_tdata,
    output logic [WIDTH/8-1:0]           m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [32*NUM_PORTS-1:0]      pkt_count
`endif
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int KW = WIDTH / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     next_grant;
    logic              any_valid;
    int unsigned       rr_idx;
    logic              out_free;
    logic              accept;
    logic [WIDTH-1:0]  sel_data;
    logic [KW-1:0]     sel_keep;
    logic              sel_last;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = !m_axis_tvalid || m_axis_tready;

    always_comb begin
        next_grant = '0;
        any_valid  = 1'b0;
        rr_idx     = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            rr_idx = (32'(last_grant) + k) % NUM_PORTS;
            if (!any_valid && s_axis_tvalid[rr_idx]) begin
                any_valid  = 1'b1;
                next_grant = rr_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = s_axis_tdata[32'(grant_idx) * WIDTH +: WIDTH];
        sel_keep = s_axis_tkeep[32'(grant_idx) * KW +: KW];
        sel_last = s_axis_tlast[grant_idx];
    end

    always_comb begin
        s_axis_tready = '0;
        if (state == BUSY)
            s_axis_tready[grant_idx] = out_free;
    end

    assign accept = s_axis_tvalid[grant_idx] && s_axis_tready[grant_idx];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= IDLE;
            grant_idx     <= '0;
            last_grant    <= IW'(NUM_PORTS - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sel_data;
                m_axis_tkeep  <= sel_keep;
                m_axis_tlast  <= sel_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_idx <= next_grant;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && sel_last) begin
                        last_grant <= grant_idx;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIS_ARB_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset)
            pkt_count <= '0;
        else if (accept && sel_last)
            pkt_count[32'(grant_idx) * 32 +: 32] <= pkt_count[32'(grant_idx) * 32 +: 32] + 32'd1;
    end
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: directed scenarios plus randomized traffic,
// compared each cycle against a packet-level reference model.
`timescale 1ns/1ps
module tb_axis_packet_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int KW = W / 8;
    localparam int IW = 2;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic              aclk;
    logic              areset;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tready;
    logic [N*W-1:0]    s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N-1:0]      s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [W-1:0]      m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
    logic [IW-1:0]     grant_idx;
`ifdef AXIS_ARB_STATS_EN
    logic [32*N-1:0]   pkt_count;
`endif

    axis_packet_arbiter #(.NUM_PORTS(N), .WIDTH(W)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .grant_idx(grant_idx)
`ifdef AXIS_ARB_STATS_EN
        , .pkt_count(pkt_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Stimulus sources: per-port beat store with head/tail pointers.
    beat_t mem [N][DEPTH];
    int    head [N];
    int    tail [N];
    bit    vld [N];
    bit    hs [N];
    int    pause [N];
    int    pause_at [N];
    int    vprob [N];
    int    rprob;
    int    stall;

    // Reference model: which port owns the output (-1 = none), round-robin history, output slot.
    int          owner;
    int          lastg;
    int          gexp;
    bit          ovalid;
    beat_t       obeat;
    int unsigned cnt [N];
    bit          model_valid;

    int n_checks;
    int n_fail;
    int cyc;
    int beats_out;
    int order_q [$];
    int last_cyc [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_pkt(input int p, input int len);
        logic [31:0] r;
        for (int b = 0; b < len; b++) begin
            r = $urandom();
            mem[p][tail[p]].data = {4'(p), r[27:0]};
            mem[p][tail[p]].keep = r[31:28];
            mem[p][tail[p]].last = (b == len - 1);
            tail[p]++;
        end
    endtask

    task automatic clear_sources();
        for (int p = 0; p < N; p++) begin
            vld[p] = 0; hs[p] = 0; head[p] = 0; tail[p] = 0;
            pause[p] = 0; pause_at[p] = -1;
        end
        stall = 0;
    endtask

    function automatic int pending();
        int s = 0;
        for (int p = 0; p < N; p++) s += tail[p] - head[p];
        if (owner >= 0) s++;
        if (ovalid) s++;
        return s;
    endfunction

    // Called at the falling edge: advance sources on last handshake, then drive the buses.
    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (vld[p] && hs[p]) begin
                head[p]++;
                vld[p] = 0;
                if (pause_at[p] == tail[p] - head[p]) begin
                    pause[p] = 2;
                    pause_at[p] = -1;
                end
            end
            if (pause[p] > 0)
                pause[p]--;
            else if (!vld[p] && head[p] < tail[p] && $urandom_range(0, 99) < vprob[p])
                vld[p] = 1;
            s_axis_tvalid[p] = vld[p];
            if (head[p] < tail[p]) begin
                s_axis_tdata[p*W +: W]   = mem[p][head[p]].data;
                s_axis_tkeep[p*KW +: KW] = mem[p][head[p]].keep;
                s_axis_tlast[p]          = mem[p][head[p]].last;
            end else begin
                s_axis_tdata[p*W +: W]   = '0;
                s_axis_tkeep[p*KW +: KW] = '0;
                s_axis_tlast[p]          = 1'b0;
            end
        end
        if (stall > 0) begin
            stall--;
            m_axis_tready = 1'b0;
        end else begin
            m_axis_tready = ($urandom_range(0, 99) < rprob);
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_rdy;
        bit           room;
        bit           found;
        int           pp;
        #1;
        room = !ovalid || m_axis_tready;
        exp_rdy = '0;
        if (owner >= 0 && room) exp_rdy[owner] = 1'b1;
        if (model_valid) begin
            check_eq("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
            check_eq("grant_idx", 64'(grant_idx), 64'(gexp));
            check_eq("m_tvalid", 64'(m_axis_tvalid), 64'(ovalid));
            check_eq("m_tdata", 64'(m_axis_tdata), 64'(obeat.data));
            check_eq("m_tkeep", 64'(m_axis_tkeep), 64'(obeat.keep));
            check_eq("m_tlast", 64'(m_axis_tlast), 64'(obeat.last));
`ifdef AXIS_ARB_STATS_EN
            for (int p = 0; p < N; p++)
                check_eq("pkt_count", 64'(pkt_count[p*32 +: 32]), 64'(cnt[p]));
`endif
        end
        for (int p = 0; p < N; p++) hs[p] = s_axis_tvalid[p] && s_axis_tready[p];
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            beats_out++;
            if (m_axis_tlast) begin
                order_q.push_back(int'(m_axis_tdata[W-1 -: 4]));
                last_cyc.push_back(cyc);
            end
        end
        if (areset) begin
            owner = -1; lastg = N - 1; gexp = 0; ovalid = 0; obeat = '0;
            for (int p = 0; p < N; p++) cnt[p] = 0;
            model_valid = 1;
        end else if (owner < 0) begin
            if (m_axis_tready) ovalid = 0;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                pp = (lastg + k) % N;
                if (!found && s_axis_tvalid[pp]) begin
                    found = 1; owner = pp; gexp = pp;
                end
            end
        end else if (s_axis_tvalid[owner] && room) begin
            ovalid = 1;
            obeat  = mem[owner][head[owner]];
            if (obeat.last) begin
                cnt[owner]++;
                lastg = owner;
                owner = -1;
            end
        end else if (m_axis_tready) begin
            ovalid = 0;
        end
        @(posedge aclk);
        @(negedge aclk);
        cyc++;
    endtask

    task automatic step();
        drive();
        tick();
    endtask

    task automatic do_reset();
        clear_sources();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
        order_q.delete();
        last_cyc.delete();
        beats_out = 0;
    endtask

    task automatic run_until_drained(input string tag, input int limit);
        int n = 0;
        while (pending() > 0 && n < limit) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, 64'(pending()), 64'd0);
        step();
    endtask

    task automatic directed_mode();
        for (int p = 0; p < N; p++) vprob[p] = 100;
        rprob = 100;
    endtask

    initial begin
        int exp28 [6];
        n_checks = 0; n_fail = 0; cyc = 0; beats_out = 0; model_valid = 0;
        owner = -1; lastg = N - 1; gexp = 0; ovalid = 0; obeat = '0;
        areset = 1'b0; m_axis_tready = 1'b0;
        s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0;
        directed_mode();
        clear_sources();
        @(negedge aclk);

        // Reset state and a 3-beat packet on port 2.
        do_reset();
        check_eq("reset_grant", 64'(grant_idx), 64'd0);
        check_eq("reset_mvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("reset_tready", 64'(s_axis_tready), 64'd0);
        push_pkt(2, 3);
        step();
        check_eq("r27_grant", 64'(grant_idx), 64'd2);
        run_until_drained("r27", 50);
        check_eq("r27_beats", 64'(beats_out), 64'd3);
        check_eq("r27_pkts", 64'(order_q.size()), 64'd1);
        if (order_q.size() > 0) check_eq("r27_port", 64'(order_q[0]), 64'd2);

        // Round-robin over ports 0,1,3 with single-beat packets.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_pkt(0, 1); push_pkt(1, 1); push_pkt(3, 1);
        end
        run_until_drained("r28", 60);
        exp28 = '{0, 1, 3, 0, 1, 3};
        check_eq("r28_pkts", 64'(order_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < order_q.size(); i++) begin
            check_eq("r28_order", 64'(order_q[i]), 64'(exp28[i]));
            if (i > 0) check_eq("r28_gap", 64'(last_cyc[i] - last_cyc[i-1]), 64'd2);
        end

        // Granted port pauses mid-packet while port 0 requests.
        do_reset();
        push_pkt(1, 4);
        pause_at[1] = 2;
        step();
        check_eq("r29_grant", 64'(grant_idx), 64'd1);
        push_pkt(0, 1);
        run_until_drained("r29", 60);
        check_eq("r29_beats", 64'(beats_out), 64'd5);
        check_eq("r29_pkts", 64'(order_q.size()), 64'd2);
        if (order_q.size() == 2) begin
            check_eq("r29_first", 64'(order_q[0]), 64'd1);
            check_eq("r29_second", 64'(order_q[1]), 64'd0);
        end

        // Output back-pressure for 5 cycles mid-packet.
        do_reset();
        push_pkt(0, 4);
        step();
        step();
        stall = 5;
        run_until_drained("r30", 60);
        check_eq("r30_beats", 64'(beats_out), 64'd4);
        check_eq("r30_pkts", 64'(order_q.size()), 64'd1);

        // Reset in the middle of a 4-beat packet; port 0 must win afterwards.
        do_reset();
        push_pkt(1, 4);
        step(); step(); step();
        clear_sources();
        areset = 1'b1;
        step();
        areset = 1'b0;
        check_eq("r31_mvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("r31_grant", 64'(grant_idx), 64'd0);
        push_pkt(1, 2);
        push_pkt(0, 2);
        step();
        check_eq("r31_winner", 64'(grant_idx), 64'd0);
        order_q.delete();
        run_until_drained("r31", 60);
        check_eq("r31_pkts", 64'(order_q.size()), 64'd2);
        if (order_q.size() == 2) begin
            check_eq("r31_first", 64'(order_q[0]), 64'd0);
            check_eq("r31_second", 64'(order_q[1]), 64'd1);
        end

`ifdef AXIS_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) push_pkt(0, $urandom_range(1, 3));
        for (int i = 0; i < 2; i++) push_pkt(3, $urandom_range(1, 3));
        run_until_drained("r32", 200);
        check_eq("r32_cnt0", 64'(pkt_count[31:0]), 64'd5);
        check_eq("r32_cnt1", 64'(pkt_count[63:32]), 64'd0);
        check_eq("r32_cnt2", 64'(pkt_count[95:64]), 64'd0);
        check_eq("r32_cnt3", 64'(pkt_count[127:96]), 64'd2);
`endif

        // Randomized traffic with source gaps and sink back-pressure.
        for (int p = 0; p < N; p++) vprob[p] = $urandom_range(20, 100);
        rprob = $urandom_range(40, 100);
        do_reset();
        for (int p = 0; p < N; p++)
            for (int i = 0; i < 15; i++) push_pkt(p, $urandom_range(1, 6));
        run_until_drained("rand", 5000);
        check_eq("rand_pkts", 64'(order_q.size()), 64'(15 * N));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of slave AXI-stream requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 512, tdata width in bits; tkeep width is WIDTH/8.
REQ-003 SHALL have port aclk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port areset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port s_axis_tvalid  in  NUM_PORTS  per-requester valid.
REQ-006 SHALL have port s_axis_tready  out  NUM_PORTS  per-requester ready.
REQ-007 SHALL have port s_axis_tdata  in  NUM_PORTS*WIDTH  packed data, port i at [i*WIDTH +: WIDTH].
REQ-008 SHALL have port s_axis_tkeep  in  NUM_PORTS*WIDTH/8  packed keep.
REQ-009 SHALL have port s_axis_tlast  in  NUM_PORTS  per-requester last.
REQ-010 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/WIDTH/WIDTH/8/1  shared output stream.
REQ-011 SHALL have port grant_idx  out  $clog2(NUM_PORTS)  index of current/last granted port.

Function
REQ-012 SHALL implement FSM with states IDLE and BUSY.
REQ-013 In IDLE, if any s_axis_tvalid is high, SHALL select the first valid port in round-robin order starting at last_grant+1 (mod NUM_PORTS), register it in grant_idx, and enter BUSY next cycle.
REQ-014 In IDLE, all s_axis_tready SHALL be 0.
REQ-015 In BUSY, only s_axis_tready[grant_idx] SHALL be driven, equal to (!m_axis_tvalid || m_axis_tready); all others 0.
REQ-016 Output SHALL be a one-stage register: an accepted input beat appears on m_axis the cycle after acceptance.
REQ-017 m_axis data/keep/last SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 Grant SHALL be held for the whole packet; a deasserted tvalid on the granted port mid-packet SHALL not release the grant.
REQ-019 On acceptance of a beat with tlast=1 on the granted port, FSM SHALL return to IDLE next cycle and last_grant SHALL update to grant_idx.
REQ-020 Single-beat packets SHALL be handled identically (grant, one beat, return to IDLE).
REQ-021 Inter-packet overhead SHALL be exactly one IDLE cycle; within a packet, throughput SHALL be one beat/cycle while m_axis_tready=1.
REQ-022 Requests arriving on other ports during BUSY SHALL be ignored until the next IDLE evaluation.

Reset
REQ-023 When areset=1 at a clock edge: FSM to IDLE, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, s_axis_tready=0, grant_idx=0, last_grant=NUM_PORTS-1 (port 0 has first priority).
REQ-024 Reset mid-packet SHALL discard the output register contents and any grant; no partial-packet recovery.

Configuration
REQ-025 Macro AXIS_ARB_STATS_EN, when defined, SHALL add output pkt_count  out  32*NUM_PORTS: per-port packet counters, incremented when a tlast beat from that port is accepted, wrapping at 2^32, cleared by areset.
REQ-026 Without AXIS_ARB_STATS_EN, pkt_count port and counters SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset, then port 2 sends 3-beat packet, m_axis_tready=1 -> grant_idx=2 one cycle after valid, 3 beats on m_axis with tlast on third, FSM IDLE next cycle.
REQ-028 Ports 0,1,3 all valid with 1-beat packets continuously -> output order 0,1,3,0,1,3; one bubble cycle between packets.
REQ-029 Port 1 mid 4-beat packet drops tvalid 2 cycles while port 0 valid -> grant stays 1, s_axis_tready[0]=0, packet completes uninterrupted.
REQ-030 m_axis_tready held 0 for 5 cycles during a packet -> m_axis_tdata/tkeep/tlast stable, granted s_axis_tready=0, no beat lost or duplicated.
REQ-031 areset pulsed during beat 2 of a 4-beat packet -> next cycle m_axis_tvalid=0, grant_idx=0, port 0 wins next arbitration.
REQ-032 With AXIS_ARB_STATS_EN: 5 packets on port 0, 2 on port 3 -> pkt_count[31:0]=5, pkt_count[127:96]=2, others 0.
